// File: rtl/alu_seq_if.sv
// Handshake and result bundle between the register-file read side, the ALU and write-back.
// master drives operands and out_ready; slave (the ALU) drives result, flags and in_ready.
interface alu_seq_if #(
  parameter int N      = 8,
  parameter int MODE_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [MODE_W-1:0] mode;
  logic [N-1:0]      in_a;
  logic [N-1:0]      in_b;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      out;
  logic [N-1:0]      out_hi;
  logic              flag_zero;
  logic              flag_carry;
  logic              flag_neg;
  logic              flag_ovf;
  logic              op_err;

  modport master (
    output in_valid, mode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out, out_hi,
           flag_zero, flag_carry, flag_neg, flag_ovf, op_err
  );

  modport slave (
    input  in_valid, mode, in_a, in_b, out_ready,
    output in_ready, out_valid, out, out_hi,
           flag_zero, flag_carry, flag_neg, flag_ovf, op_err
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic/shift ops, N-cycle shift-add multiply,
// carry-chained ADC/SBC, valid/ready on both sides with result and flags held until taken.
module alu_seq #(
  parameter int N      = 8,
  parameter int MODE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  localparam int SW = $clog2(N);

  localparam logic [MODE_W-1:0] OP_ADD = MODE_W'(0);
  localparam logic [MODE_W-1:0] OP_SUB = MODE_W'(1);
  localparam logic [MODE_W-1:0] OP_AND = MODE_W'(2);
  localparam logic [MODE_W-1:0] OP_OR  = MODE_W'(3);
  localparam logic [MODE_W-1:0] OP_XOR = MODE_W'(4);
  localparam logic [MODE_W-1:0] OP_SHL = MODE_W'(5);
  localparam logic [MODE_W-1:0] OP_SHR = MODE_W'(6);
  localparam logic [MODE_W-1:0] OP_SAR = MODE_W'(7);
  localparam logic [MODE_W-1:0] OP_MUL = MODE_W'(8);
  localparam logic [MODE_W-1:0] OP_ADC = MODE_W'(9);
  localparam logic [MODE_W-1:0] OP_SBC = MODE_W'(10);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic              c_reg;
  logic [N-1:0]      res;
  logic [N-1:0]      res_hi;
  logic              f_zero;
  logic              f_carry;
  logic              f_neg;
  logic              f_ovf;
  logic              f_err;

  logic [2*N-1:0]    mcand;
  logic [2*N-1:0]    prod;
  logic [2*N-1:0]    prod_next;
  logic [N-1:0]      mplier;
  logic [SW-1:0]     cnt;

  logic [SW-1:0]     amt;
  logic              cin;
  logic              bin;
  logic [N:0]        add_r;
  logic [N:0]        sub_r;
  logic [N:0]        shl_r;
  logic [N:0]        shr_r;
  logic signed [N:0] sar_src;
  logic signed [N:0] sar_r;

  logic [N-1:0]      sc_out;
  logic              sc_carry;
  logic              sc_ovf;
  logic              sc_err;

  function automatic logic ovf_add(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic ovf_sub(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  // Single-cycle datapath: shifts run on an N+1 bit frame so the bit
  // pushed past the edge lands in a spare position and becomes the carry.
  always_comb begin
    amt      = bus.in_b[SW-1:0];
    cin      = (bus.mode == OP_ADC) & c_reg;
    bin      = (bus.mode == OP_SBC) & c_reg;
    add_r    = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {{N{1'b0}}, cin};
    sub_r    = {1'b0, bus.in_a} - {1'b0, bus.in_b} - {{N{1'b0}}, bin};
    shl_r    = {1'b0, bus.in_a} << amt;
    shr_r    = {bus.in_a, 1'b0} >> amt;
    sar_src  = {bus.in_a, 1'b0};
    sar_r    = sar_src >>> amt;
    sc_out   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_err   = 1'b0;
    case (bus.mode)
      OP_ADD, OP_ADC: begin
        sc_out   = add_r[N-1:0];
        sc_carry = add_r[N];
        sc_ovf   = ovf_add(bus.in_a[N-1], bus.in_b[N-1], add_r[N-1]);
      end
      OP_SUB, OP_SBC: begin
        sc_out   = sub_r[N-1:0];
        sc_carry = sub_r[N];
        sc_ovf   = ovf_sub(bus.in_a[N-1], bus.in_b[N-1], sub_r[N-1]);
      end
      OP_AND: sc_out = bus.in_a & bus.in_b;
      OP_OR:  sc_out = bus.in_a | bus.in_b;
      OP_XOR: sc_out = bus.in_a ^ bus.in_b;
      OP_SHL: begin
        sc_out   = shl_r[N-1:0];
        sc_carry = shl_r[N];
      end
      OP_SHR: begin
        sc_out   = shr_r[N:1];
        sc_carry = shr_r[0];
      end
      OP_SAR: begin
        sc_out   = sar_r[N:1];
        sc_carry = sar_r[0];
      end
      OP_MUL: sc_out = '0;
      default: sc_err = 1'b1;
    endcase
  end

  assign prod_next = prod + (mplier[0] ? mcand : '0);

  // Control FSM; result registers only change on leaving IDLE or BUSY,
  // which keeps them stable for as long as DONE is back-pressured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      c_reg   <= 1'b0;
      res     <= '0;
      res_hi  <= '0;
      f_zero  <= 1'b0;
      f_carry <= 1'b0;
      f_neg   <= 1'b0;
      f_ovf   <= 1'b0;
      f_err   <= 1'b0;
      mcand   <= '0;
      prod    <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.mode == OP_MUL) begin
              mcand  <= {{N{1'b0}}, bus.in_a};
              mplier <= bus.in_b;
              prod   <= '0;
              cnt    <= '0;
              state  <= BUSY;
            end else begin
              res     <= sc_out;
              res_hi  <= '0;
              f_zero  <= (sc_out == '0);
              f_carry <= sc_carry;
              f_neg   <= sc_out[N-1];
              f_ovf   <= sc_ovf;
              f_err   <= sc_err;
              state   <= DONE;
            end
          end
        end
        BUSY: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == SW'(N-1)) begin
            res     <= prod_next[N-1:0];
            res_hi  <= prod_next[2*N-1:N];
            f_zero  <= (prod_next == '0);
            f_carry <= |prod_next[2*N-1:N];
            f_neg   <= prod_next[N-1];
            f_ovf   <= 1'b0;
            f_err   <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            c_reg <= f_carry;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.out        = res;
  assign bus.out_hi     = res_hi;
  assign bus.flag_zero  = f_zero;
  assign bus.flag_carry = f_carry;
  assign bus.flag_neg   = f_neg;
  assign bus.flag_ovf   = f_ovf;
  assign bus.op_err     = f_err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random bench for alu_seq: expected results queued at accept, checked at output.
module tb_alu_seq;

  logic clk;
  logic rst_n;

  alu_seq_if #(.N(8), .MODE_W(4)) bus ();

  alu_seq #(.N(8), .MODE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] o;
    logic [7:0] hi;
    logic       z;
    logic       c;
    logic       n;
    logic       v;
    logic       e;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   lat;
  logic model_c = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   r;
    int   s;
    int   ai;
    int   bi;
    int   sa;
    int   sbv;
    int   amt;
    ai  = int'(a);
    bi  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    amt = int'(b[2:0]);
    e.o = 8'h00; e.hi = 8'h00; e.c = 1'b0; e.v = 1'b0; e.e = 1'b0;
    e.lat = (m == 4'd8) ? 9 : 1;
    case (m)
      4'd0, 4'd9: begin
        r = ai + bi + ((m == 4'd9) ? int'(model_c) : 0);
        s = sa + sbv + ((m == 4'd9) ? int'(model_c) : 0);
        e.o = r[7:0]; e.c = (r > 255); e.v = (s > 127) || (s < -128);
      end
      4'd1, 4'd10: begin
        r = ai - bi - ((m == 4'd10) ? int'(model_c) : 0);
        s = sa - sbv - ((m == 4'd10) ? int'(model_c) : 0);
        e.o = r[7:0]; e.c = (r < 0); e.v = (s > 127) || (s < -128);
      end
      4'd2: e.o = a & b;
      4'd3: e.o = a | b;
      4'd4: e.o = a ^ b;
      4'd5: begin
        e.o = a;
        for (int k = 0; k < amt; k++) begin e.c = e.o[7]; e.o = {e.o[6:0], 1'b0}; end
      end
      4'd6: begin
        e.o = a;
        for (int k = 0; k < amt; k++) begin e.c = e.o[0]; e.o = {1'b0, e.o[7:1]}; end
      end
      4'd7: begin
        e.o = a;
        for (int k = 0; k < amt; k++) begin e.c = e.o[0]; e.o = {e.o[7], e.o[7:1]}; end
      end
      4'd8: begin
        r = ai * bi;
        e.o = r[7:0]; e.hi = r[15:8]; e.c = (e.hi != 8'h00);
      end
      default: e.e = 1'b1;
    endcase
    e.z = ({e.hi, e.o} == 16'h0000);
    e.n = e.o[7];
    return e;
  endfunction

  task automatic issue(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
    int guard;
    bus.mode     = m;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    chk("accept_wait", 32'(guard < 50), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = 8'($urandom);
    bus.in_b     = 8'($urandom);
    bus.mode     = 4'($urandom);
    sb.push_back(model(m, a, b));
    lat = 1;
  endtask

  task automatic cmp_out(input string p, input exp_t e);
    chk({p, "_out"},    32'(bus.out),        32'(e.o));
    chk({p, "_out_hi"}, 32'(bus.out_hi),     32'(e.hi));
    chk({p, "_zero"},   32'(bus.flag_zero),  32'(e.z));
    chk({p, "_carry"},  32'(bus.flag_carry), 32'(e.c));
    chk({p, "_neg"},    32'(bus.flag_neg),   32'(e.n));
    chk({p, "_ovf"},    32'(bus.flag_ovf),   32'(e.v));
    chk({p, "_op_err"}, 32'(bus.op_err),     32'(e.e));
  endtask

  task automatic collect(input string p, input int hold);
    int   guard;
    exp_t e;
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 40) begin
      chk({p, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1; lat++; guard++;
    end
    chk({p, "_out_valid_wait"}, 32'(guard < 40), 32'd1);
    if (sb.size() == 0) begin
      chk({p, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({p, "_latency"}, 32'(lat), 32'(e.lat));
    cmp_out(p, e);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({p, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({p, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      cmp_out({p, "_hold"}, e);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    model_c = e.c;
    chk({p, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({p, "_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string p);
    chk({p, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({p, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({p, "_out"},       32'(bus.out),       32'd0);
    chk({p, "_out_hi"},    32'(bus.out_hi),    32'd0);
    chk({p, "_flags"},     32'({bus.flag_zero, bus.flag_carry, bus.flag_neg, bus.flag_ovf}), 32'd0);
    chk({p, "_op_err"},    32'(bus.op_err),    32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode      = 4'd0;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(4'd0, 8'hFF, 8'h01); collect("add_ff_01", 0);
    issue(4'd1, 8'h05, 8'h07); collect("sub_05_07", 0);
    issue(4'd0, 8'h7F, 8'h01); collect("add_7f_01", 0);
    issue(4'd0, 8'hFF, 8'h01); collect("add_carry_set", 0);
    issue(4'd9, 8'h00, 8'h00); collect("adc_00_00", 0);
    issue(4'd8, 8'h10, 8'h20); collect("mul_10_20", 0);
    issue(4'd7, 8'h81, 8'h01); collect("sar_81_1", 5);
    issue(4'd2, 8'hF0, 8'h3C); collect("and", 0);
    issue(4'd3, 8'hF0, 8'h0F); collect("or", 0);
    issue(4'd4, 8'hAA, 8'hAA); collect("xor_zero", 0);
    issue(4'd5, 8'hC3, 8'h00); collect("shl_by0", 0);
    issue(4'd5, 8'h41, 8'h02); collect("shl_by2", 0);
    issue(4'd6, 8'h81, 8'h07); collect("shr_by7", 0);
    issue(4'd7, 8'h7E, 8'h03); collect("sar_pos", 0);
    issue(4'd1, 8'h00, 8'h01); collect("sub_borrow", 0);
    issue(4'd10, 8'h80, 8'h00); collect("sbc_ovf", 0);
    issue(4'd8, 8'hFF, 8'hFF); collect("mul_ff_ff", 0);
    issue(4'd8, 8'h00, 8'h5A); collect("mul_zero", 0);
    issue(4'd0, 8'hFF, 8'hFF); collect("add_set_c", 0);
    issue(4'd12, 8'h12, 8'h34); collect("undef_op", 0);
    issue(4'd9, 8'h01, 8'h01); collect("adc_after_undef", 0);

    for (int i = 0; i < 24; i++) begin
      issue(4'($urandom_range(0, 12)), 8'($urandom), 8'($urandom));
      collect("random", int'($urandom_range(0, 2)));
    end

    issue(4'd0, 8'hFF, 8'h01); collect("pre_abort_add", 0);
    issue(4'd8, 8'h33, 8'h44);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_mul");
    void'(sb.pop_front());
    model_c = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("abort_mul_held");
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(4'd9, 8'h01, 8'h01); collect("adc_after_abort", 0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
